// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one RAM port between the CPU datapath and a DMA/loader
// requester. Each access is arbitrated on its own. When both sides request
// at once, the side that was not served last wins. The DMA side can lock the
// port for a burst of up to MAX_BURST accesses.
//
// Ports:
//   clk, ena                  clock; synchronous active-low reset
//   cpu_req/wr/addr/wdata     CPU command, held until cpu_ack
//   cpu_gnt/ack/rdata         CPU grant, one-cycle completion pulse, read data
//   cpu_hold                  combinational stall: cpu_req & ~cpu_ack
//   dma_req/wr/addr/wdata     DMA command, same handshake as the CPU side
//   dma_lock                  DMA request for exclusive burst ownership
//   dma_gnt/ack/rdata         DMA grant, completion pulse, read data
//   mem_addr/wdata/rd/wr      registered RAM command
//   mem_rdata                 RAM read data, valid the cycle after mem_rd
module bus_arbiter #(
  parameter int unsigned AW        = 13,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          ena,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_hold,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned BW = $clog2(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [2:0] {IDLE, C_ACC, C_ACK, D_ACC, D_ACK, D_HOLD} state_e;

  state_e        state_q, state_d;
  logic          last_dma_q, last_dma_d;
  logic          lock_q, lock_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          load_cpu, load_dma;

  logic          cmd_wr_q, cmd_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic          cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
  logic          cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

  // A requester is ignored during its own ack cycle, so a held req is not
  // mistaken for a second access.
  logic cpu_v, dma_v;
  assign cpu_v = cpu_req & ~cpu_ack_q;
  assign dma_v = dma_req & ~dma_ack_q;

  // State register plus arbitration bookkeeping
  always_ff @(posedge clk) begin
    if (!ena) begin
      state_q     <= IDLE;
      last_dma_q  <= 1'b1;
      lock_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      lock_q      <= lock_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state logic and command-latch selection
  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    lock_d      = lock_q;
    burst_cnt_d = burst_cnt_q;
    load_cpu    = 1'b0;
    load_dma    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_v && (!dma_v || last_dma_q)) begin
          state_d  = C_ACC;
          load_cpu = 1'b1;
        end else if (dma_v) begin
          state_d     = D_ACC;
          load_dma    = 1'b1;
          lock_d      = dma_lock;
          burst_cnt_d = '0;
        end
      end
      C_ACC: state_d = C_ACK;
      C_ACK: begin
        state_d    = IDLE;
        last_dma_d = 1'b0;
      end
      D_ACC: state_d = D_ACK;
      D_ACK: begin
        last_dma_d = 1'b1;
        // Stay owned only while the lock is still asserted and the burst has room
        if (lock_q && dma_lock && (burst_cnt_q < BURST_LAST)) state_d = D_HOLD;
        else                                                  state_d = IDLE;
      end
      D_HOLD: begin
        if (dma_v) begin
          state_d     = D_ACC;
          load_dma    = 1'b1;
          burst_cnt_d = BW'(burst_cnt_q + 1'b1);
        end else if (!dma_lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered output values, derived from the upcoming state
  always_comb begin
    cmd_wr_d    = cmd_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    if (load_cpu) begin
      cmd_wr_d    = cpu_wr;
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      mem_rd_d    = ~cpu_wr;
      mem_wr_d    = cpu_wr;
    end else if (load_dma) begin
      cmd_wr_d    = dma_wr;
      mem_addr_d  = dma_addr;
      mem_wdata_d = dma_wdata;
      mem_rd_d    = ~dma_wr;
      mem_wr_d    = dma_wr;
    end
    cpu_gnt_d = (state_d == C_ACC) || (state_d == C_ACK);
    dma_gnt_d = (state_d == D_ACC) || (state_d == D_ACK) || (state_d == D_HOLD);
    cpu_ack_d = (state_q == C_ACK);
    dma_ack_d = (state_q == D_ACK);
    // RAM data arrives during the ACK cycle; writes keep the old read data
    if ((state_q == C_ACK) && !cmd_wr_q) cpu_rdata_d = mem_rdata;
    if ((state_q == D_ACK) && !cmd_wr_q) dma_rdata_d = mem_rdata;
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!ena) begin
      cmd_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cmd_wr_q    <= cmd_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_hold  = cpu_req & ~cpu_ack_q;
  assign cpu_gnt   = cpu_gnt_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_gnt   = dma_gnt_q;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. It holds a behavioural RAM and keeps
// per-requester scoreboards of expected memory commands and read data.
module tb_bus_arbiter;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          ena, cpu_req, cpu_wr, dma_req, dma_wr, dma_lock;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_ack, cpu_hold, dma_gnt, dma_ack;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata = '0;

  bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk(clk), .ena(ena),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  acc_t          cpu_mq[$], dma_mq[$];
  logic [DW-1:0] cpu_rq[$], dma_rq[$];
  logic [DW-1:0] last_rd[2];
  logic [DW-1:0] written[logic [AW-1:0]];
  bit            own_log[$];
  bit            mon_en = 1'b0;
  bit            prev_strobe = 1'b0;
  logic [DW-1:0] ram[0:(1<<AW)-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    if (a == 13'h0012) return 8'hA5;
    return a[7:0] ^ 8'h5A ^ {3'b000, a[12:8]};
  endfunction

  function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
    if (written.exists(a)) return written[a];
    return pat(a);
  endfunction

  // Behavioural RAM: read data appears the cycle after mem_rd
  always @(posedge clk) begin
    if (mem_rd === 1'b1) mem_rdata <= ram[mem_addr];
    if (mem_wr === 1'b1) ram[mem_addr] <= mem_wdata;
  end

  // Bus monitor: grant exclusivity, strobe shape, command contents, owner order
  always @(negedge clk) begin : monitor
    acc_t e;
    if (mon_en) begin
      check("gnt_excl", 32'(cpu_gnt & dma_gnt), 0);
      if (mem_rd || mem_wr) begin
        check("rd_wr_excl", 32'(mem_rd & mem_wr), 0);
        check("strobe_single", 32'(prev_strobe), 0);
        check("strobe_one_gnt", 32'(cpu_gnt ^ dma_gnt), 1);
        if (dma_gnt && dma_mq.size() == 0) check("dma_unexpected_access", 1, 0);
        else if (!dma_gnt && cpu_mq.size() == 0) check("cpu_unexpected_access", 1, 0);
        else begin
          e = dma_gnt ? dma_mq.pop_front() : cpu_mq.pop_front();
          check("mem_wr_kind", 32'(mem_wr), 32'(e.wr));
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          if (e.wr) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          own_log.push_back(dma_gnt);
        end
      end
      prev_strobe = mem_rd | mem_wr;
    end
  end

  // Drive a command and queue what it should produce
  task automatic issue(input bit d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    acc_t e;
    logic [DW-1:0] r;
    e.wr = wr; e.addr = a; e.wdata = wd;
    if (wr) begin
      r = last_rd[d];
      written[a] = wd;
    end else begin
      r = exp_mem(a);
      last_rd[d] = r;
    end
    if (d) begin
      dma_req = 1'b1; dma_wr = wr; dma_addr = a; dma_wdata = wd;
      dma_mq.push_back(e); dma_rq.push_back(r);
    end else begin
      cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
      cpu_mq.push_back(e); cpu_rq.push_back(r);
    end
  endtask

  // Wait (bounded) for the ack pulse, compare read data, optionally drop req
  task automatic wait_ack(input bit d, input bit drop);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((d ? dma_ack : cpu_ack) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      if (d) check("dma_ack_timeout", 0, 1);
      else   check("cpu_ack_timeout", 0, 1);
    end else if (d) begin
      check("dma_rdata", 32'(dma_rdata), 32'(dma_rq.pop_front()));
    end else begin
      check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_rq.pop_front()));
      check("cpu_hold_at_ack", 32'(cpu_hold), 0);
    end
    if (drop) begin
      if (d) dma_req = 1'b0;
      else   cpu_req = 1'b0;
    end
  endtask

  task automatic check_log(input string tag, input bit exp[$]);
    check({tag, "_len"}, 32'(own_log.size()), 32'(exp.size()));
    if (own_log.size() == exp.size())
      for (int i = 0; i < exp.size(); i++) check({tag, "_owner"}, 32'(own_log[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [DW-1:0] prev;
    bit found;
    for (int i = 0; i < (1 << AW); i++) ram[i] = pat(AW'(i));
    last_rd[0] = '0; last_rd[1] = '0;

    // Reset with both requests asserted
    ena = 1'b0; dma_lock = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0100; cpu_wdata = '0;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 13'h0200; dma_wdata = '0;
    @(negedge clk); @(negedge clk);
    mon_en = 1'b1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 0);
    check("rst_dma_gnt", 32'(dma_gnt), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_dma_ack", 32'(dma_ack), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_dma_rdata", 32'(dma_rdata), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 1);

    // Release: CPU wins the first tie, then strict alternation
    own_log.delete();
    issue(0, 0, 13'h0100, 8'h00);
    issue(1, 0, 13'h0200, 8'h00);
    ena = 1'b1;
    @(negedge clk);
    check("first_cpu_gnt", 32'(cpu_gnt), 1);
    check("first_dma_gnt", 32'(dma_gnt), 0);
    fork
      begin wait_ack(0, 0); issue(0, 0, 13'h0101, 8'h00); wait_ack(0, 1); end
      begin wait_ack(1, 0); issue(1, 0, 13'h0201, 8'h00); wait_ack(1, 1); end
    join
    check_log("contention", '{1'b0, 1'b1, 1'b0, 1'b1});
    repeat (2) @(negedge clk);

    // Single CPU read with cycle-exact timing
    issue(0, 0, 13'h0012, 8'h00);
    @(negedge clk);
    check("rd_c1_mem_rd", 32'(mem_rd), 1);
    check("rd_c1_mem_wr", 32'(mem_wr), 0);
    check("rd_c1_cpu_gnt", 32'(cpu_gnt), 1);
    check("rd_c1_hold", 32'(cpu_hold), 1);
    @(negedge clk);
    check("rd_c2_mem_rd", 32'(mem_rd), 0);
    check("rd_c2_cpu_ack", 32'(cpu_ack), 0);
    check("rd_c2_hold", 32'(cpu_hold), 1);
    @(negedge clk);
    check("rd_c3_cpu_ack", 32'(cpu_ack), 1);
    check("rd_c3_rdata", 32'(cpu_rdata), 32'h0000_00A5);
    void'(cpu_rq.pop_front());
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // DMA write at the top address; dma_rdata must not move
    prev = last_rd[1];
    issue(1, 1, 13'h1FFF, 8'h3C);
    wait_ack(1, 1);
    check("dma_wr_keeps_rdata", 32'(dma_rdata), 32'(prev));
    issue(0, 0, 13'h1FFF, 8'h00);
    wait_ack(0, 1);
    repeat (2) @(negedge clk);

    // Locked burst runs to exhaustion, then the pending CPU is served
    own_log.delete();
    dma_lock = 1'b1;
    issue(1, 0, 13'h0300, 8'h00);
    issue(0, 0, 13'h0400, 8'h00);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          wait_ack(1, i == 3);
          if (i < 3) begin
            check("burst_hold_gnt", 32'(dma_gnt), 1);
            issue(1, 0, AW'(13'h0300 + i + 1), 8'h00);
          end
        end
        dma_lock = 1'b0;
        check("burst_end_gnt", 32'(dma_gnt), 0);
      end
      begin wait_ack(0, 1); end
    join
    check_log("burst", '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    repeat (2) @(negedge clk);

    // Lock dropped after two accesses: D_HOLD, IDLE, then CPU
    own_log.delete();
    dma_lock = 1'b1;
    issue(1, 0, 13'h0500, 8'h00);
    issue(0, 0, 13'h0600, 8'h00);
    fork
      begin
        wait_ack(1, 0);
        check("drop_hold_gnt1", 32'(dma_gnt), 1);
        issue(1, 0, 13'h0501, 8'h00);
        wait_ack(1, 1);
        dma_lock = 1'b0;
        check("drop_hold_gnt2", 32'(dma_gnt), 1);
        @(negedge clk);
        check("drop_idle_dma_gnt", 32'(dma_gnt), 0);
        check("drop_idle_cpu_gnt", 32'(cpu_gnt), 0);
      end
      begin wait_ack(0, 1); end
    join
    check_log("lockdrop", '{1'b1, 1'b1, 1'b0});
    repeat (2) @(negedge clk);

    // Reset during D_ACK abandons the access; a re-issue completes
    issue(1, 0, 13'h0700, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && dma_gnt === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("dack_reach_acc", 32'(found), 1);
    @(negedge clk);
    check("dack_no_ack_yet", 32'(dma_ack), 0);
    ena = 1'b0;
    @(negedge clk);
    check("dack_rst_ack", 32'(dma_ack), 0);
    check("dack_rst_dma_gnt", 32'(dma_gnt), 0);
    check("dack_rst_cpu_gnt", 32'(cpu_gnt), 0);
    check("dack_rst_rdata", 32'(dma_rdata), 0);
    void'(dma_rq.pop_back());
    last_rd[0] = '0; last_rd[1] = '0;
    issue(1, 0, 13'h0700, 8'h00);
    ena = 1'b1;
    wait_ack(1, 1);

    repeat (3) @(negedge clk);
    check("cpu_mq_empty", 32'(cpu_mq.size()), 0);
    check("dma_mq_empty", 32'(dma_mq.size()), 0);
    check("cpu_rq_empty", 32'(cpu_rq.size()), 0);
    check("dma_rq_empty", 32'(dma_rq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
